// File: rtl/opt_reg_pkg.sv
// Shared types for the skid-buffered pipeline register.
// The state encoding doubles as the occupancy count.
package opt_reg_pkg;

    localparam int OccWidth = 2;

    typedef enum logic [OccWidth-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/opt_reg_skid.sv
// Flow-controlled pipeline register with a one-entry skid buffer.
// Output word and in_ready are both registered; in_ready never depends combinationally on out_ready.
module opt_reg_skid
    import opt_reg_pkg::*;
#(
    parameter int DataWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DataWidth-1:0] res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OccWidth-1:0]  occupancy
);

    skid_state_t          state;
    skid_state_t          state_next;
    logic [DataWidth-1:0] skid;
    logic                 in_fire;
    logic                 out_fire;
    logic                 load_in;
    logic                 load_skid;
    logic                 capture_skid;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_valid = (state != EMPTY);
    assign occupancy = OccWidth'(state);

    always_comb begin
        state_next   = state;
        load_in      = 1'b0;
        load_skid    = 1'b0;
        capture_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next = ONE;
                    load_in    = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_in = 1'b1;
                end else if (in_fire) begin
                    state_next   = TWO;
                    capture_skid = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain side can move
                if (out_fire) begin
                    state_next = ONE;
                    load_skid  = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            res      <= '0;
            skid     <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != TWO);
            if (load_in) begin
                res <= data_in;
            end else if (load_skid) begin
                res <= skid;
            end
            if (capture_skid) begin
                skid <= data_in;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (occupancy != 2'd3);
        end
    end

endmodule

// File: tb/tb_opt_reg_skid.sv
// Bench for opt_reg_skid: directed scenarios plus random traffic on 16-bit and 1-bit instances,
// checked against a queue model of a two-deep FIFO with registered ready.
module tb_opt_reg_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] res;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  occupancy;

    logic        d1_data_in;
    logic        d1_in_valid;
    logic        d1_in_ready;
    logic        d1_res;
    logic        d1_out_valid;
    logic        d1_out_ready;
    logic [1:0]  d1_occupancy;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] q16[$];
    logic        q1[$];

    always #5 clk = ~clk;

    opt_reg_skid #(.DataWidth(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res       (res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    opt_reg_skid #(.DataWidth(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (d1_data_in),
        .in_valid  (d1_in_valid),
        .in_ready  (d1_in_ready),
        .res       (d1_res),
        .out_valid (d1_out_valid),
        .out_ready (d1_out_ready),
        .occupancy (d1_occupancy)
    );

    // Drive one cycle on the 16-bit instance; the model is a FIFO of at most two words,
    // ready whenever it holds fewer than two, popped before pushed on the same edge.
    task automatic cycle16(input logic v, input logic [15:0] d, input logic o);
        bit inf;
        bit outf;
        in_valid  = v;
        data_in   = d;
        out_ready = o;
        @(posedge clk);
        if (!rst) begin
            inf  = v && (q16.size() < 2);
            outf = o && (q16.size() > 0);
            if (outf) void'(q16.pop_front());
            if (inf) q16.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL por_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL por_in_ready: got %b expected 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL por_occupancy: got %0d expected 0", occupancy); end
        checks++; if (res !== 16'h0000) begin errors++; $display("FAIL por_res: got %h expected 0000", res); end
        @(negedge clk);
        rst = 1'b0;
        cycle16(1'b1, 16'h9ABC, 1'b0);
        checks++; if (res !== 16'h9ABC) begin errors++; $display("FAIL rst_pre_res: got %h expected 9abc", res); end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occupancy: got %0d expected 0", occupancy); end
        checks++; if (res !== 16'h0000) begin errors++; $display("FAIL rst_res: got %h expected 0000", res); end
        q16.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            cycle16(1'b1, 16'(i), 1'b1);
            checks++; if (res !== 16'(i)) begin errors++; $display("FAIL stream_res[%0d]: got %h expected %h", i, res, 16'(i)); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_out_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d]: got %0d expected 1", i, occupancy); end
        end
        cycle16(1'b0, 16'h0000, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        cycle16(1'b1, 16'hAAAA, 1'b0);
        cycle16(1'b1, 16'hBBBB, 1'b0);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ: got %0d expected 2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        checks++; if (res !== 16'hAAAA) begin errors++; $display("FAIL bp_res: got %h expected aaaa", res); end
        cycle16(1'b1, 16'hDEAD, 1'b0);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_hold_occ: got %0d expected 2", occupancy); end
        checks++; if (res !== 16'hAAAA) begin errors++; $display("FAIL bp_hold_res: got %h expected aaaa", res); end
        cycle16(1'b0, 16'h0000, 1'b1);
        checks++; if (res !== 16'hBBBB) begin errors++; $display("FAIL bp_second: got %h expected bbbb", res); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_second_occ: got %0d expected 1", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
        cycle16(1'b0, 16'h0000, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_simultaneous();
        cycle16(1'b1, 16'h1234, 1'b0);
        checks++; if (res !== 16'h1234) begin errors++; $display("FAIL sim_first: got %h expected 1234", res); end
        cycle16(1'b1, 16'h5678, 1'b1);
        checks++; if (res !== 16'h5678) begin errors++; $display("FAIL sim_res: got %h expected 5678", res); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL sim_occ: got %0d expected 1", occupancy); end
        cycle16(1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_reset_full();
        cycle16(1'b1, 16'hCAFE, 1'b0);
        cycle16(1'b1, 16'hBEEF, 1'b0);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rfull_occ: got %0d expected 2", occupancy); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rfull_out_valid: got %b expected 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rfull_occupancy: got %0d expected 0", occupancy); end
        checks++; if (res !== 16'h0000) begin errors++; $display("FAIL rfull_res: got %h expected 0000", res); end
        q16.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle16(1'b0, 16'hFFFF, 1'b1);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rfull_idle[%0d]: got out_valid %b expected 0", i, out_valid); end
        end
        cycle16(1'b1, 16'h7777, 1'b1);
        checks++; if (out_valid !== 1'b1 || res !== 16'h7777) begin errors++; $display("FAIL rfull_new: got %b/%h expected 1/7777", out_valid, res); end
        cycle16(1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_random16();
        for (int n = 0; n < 300; n++) begin
            cycle16(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
            checks++; if (occupancy !== 2'(q16.size())) begin errors++; $display("FAIL r16_occ[%0d]: got %0d expected %0d", n, occupancy, q16.size()); end
            checks++; if (in_ready !== (q16.size() < 2)) begin errors++; $display("FAIL r16_ready[%0d]: got %b expected %b", n, in_ready, q16.size() < 2); end
            checks++; if (out_valid !== (q16.size() > 0)) begin errors++; $display("FAIL r16_valid[%0d]: got %b expected %b", n, out_valid, q16.size() > 0); end
            if (q16.size() > 0) begin
                checks++; if (res !== q16[0]) begin errors++; $display("FAIL r16_res[%0d]: got %h expected %h", n, res, q16[0]); end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q16.size() > 0) cycle16(1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_width1();
        bit v;
        bit d;
        bit o;
        bit inf;
        bit outf;
        for (int n = 0; n < 1000; n++) begin
            v = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            o = 1'($urandom_range(0, 1));
            d1_in_valid  = v;
            d1_data_in   = d;
            d1_out_ready = o;
            @(posedge clk);
            inf  = v && (q1.size() < 2);
            outf = o && (q1.size() > 0);
            if (outf) void'(q1.pop_front());
            if (inf) q1.push_back(d);
            @(negedge clk);
            checks++; if (d1_occupancy === 2'd3) begin errors++; $display("FAIL w1_occ3[%0d]: got occupancy 3 expected at most 2", n); end
            checks++; if (d1_in_ready === 1'b1 && d1_occupancy === 2'd2) begin errors++; $display("FAIL w1_ready_full[%0d]: got in_ready 1 expected 0 at occupancy 2", n); end
            checks++; if (d1_occupancy !== 2'(q1.size())) begin errors++; $display("FAIL w1_occ[%0d]: got %0d expected %0d", n, d1_occupancy, q1.size()); end
            checks++; if (d1_out_valid !== (q1.size() > 0)) begin errors++; $display("FAIL w1_valid[%0d]: got %b expected %b", n, d1_out_valid, q1.size() > 0); end
            if (q1.size() > 0) begin
                checks++; if (d1_res !== q1[0]) begin errors++; $display("FAIL w1_res[%0d]: got %b expected %b", n, d1_res, q1[0]); end
            end
        end
        d1_in_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        data_in      = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        d1_data_in   = 1'b0;
        d1_in_valid  = 1'b0;
        d1_out_ready = 1'b0;
        #3;
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_reset_full();
        test_random16();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
